// File: rtl/block_renderer.sv
// Turns four packed block words into a one-pixel-per-cycle VGA write stream.
// Inputs are snapshotted on start; outputs are registered from the next-pixel state.
module block_renderer #(
    parameter int LEN_PX   = 16,
    parameter int THICK_PX = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] block1,
    input  logic [15:0] block2,
    input  logic [15:0] block3,
    input  logic [15:0] block4,
    input  logic [3:0]  mask,
    input  logic        start,
    input  logic        erase,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DRAW = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    localparam logic [4:0] LEN_M1   = 5'(LEN_PX - 1);
    localparam logic [4:0] THICK_M1 = 5'(THICK_PX - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0][15:0] words_q, words_d;
    logic [3:0]       msk_q, msk_d;
    logic             ers_q, ers_d;
    logic [1:0]       idx_q, idx_d;
    logic [4:0]       dx_q, dx_d;
    logic [4:0]       dy_q, dy_d;

    logic [7:0] x_d;
    logic [6:0] y_d;
    logic [2:0] colour_d;
    logic       plot_d, busy_d, done_d;

    logic       nxt_found, first_found;
    logic [1:0] nxt_idx, first_idx;
    logic [4:0] w_m1, h_m1;
    logic [15:0] cur;
    logic [8:0] sx;
    logic [7:0] sy;

    always_comb begin
        // Descending scan so the lowest qualifying index wins.
        nxt_found   = 1'b0;
        nxt_idx     = idx_q;
        first_found = 1'b0;
        first_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (msk_q[i] && (i > int'(idx_q))) begin
                nxt_found = 1'b1;
                nxt_idx   = 2'(i);
            end
            if (mask[i]) begin
                first_found = 1'b1;
                first_idx   = 2'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        words_d = words_q;
        msk_d   = msk_q;
        ers_d   = ers_q;
        idx_d   = idx_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        w_m1    = words_q[idx_q][0] ? THICK_M1 : LEN_M1;
        h_m1    = words_q[idx_q][0] ? LEN_M1 : THICK_M1;
        case (state_q)
            IDLE: begin
                if (start) begin
                    words_d = {block4, block3, block2, block1};
                    msk_d   = mask;
                    ers_d   = erase;
                    dx_d    = 5'd0;
                    dy_d    = 5'd0;
                    if (first_found) begin
                        state_d = DRAW;
                        idx_d   = first_idx;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            DRAW: begin
                if (dx_q == w_m1) begin
                    dx_d = 5'd0;
                    if (dy_q == h_m1) begin
                        dy_d = 5'd0;
                        if (nxt_found) begin
                            idx_d = nxt_idx;
                        end else begin
                            state_d = FIN;
                        end
                    end else begin
                        dy_d = dy_q + 5'd1;
                    end
                end else begin
                    dx_d = dx_q + 5'd1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are derived from the next pixel so they appear in the cycle it is drawn.
    always_comb begin
        cur      = words_d[idx_d];
        sx       = {1'b0, cur[8:1]} + {4'b0, dx_d};
        sy       = {1'b0, cur[15:9]} + {3'b0, dy_d};
        x_d      = x;
        y_d      = y;
        colour_d = colour;
        if (state_d == DRAW) begin
            x_d = sx[7:0];
            y_d = sy[6:0];
            if (ers_d) begin
                colour_d = 3'b000;
            end else begin
                case (idx_d)
                    2'd0:    colour_d = 3'b100;
                    2'd1:    colour_d = 3'b010;
                    2'd2:    colour_d = 3'b001;
                    default: colour_d = 3'b110;
                endcase
            end
        end
        plot_d = (state_d == DRAW) && (sx < 9'd160) && (sy < 8'd120);
        busy_d = (state_d == DRAW);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            words_q <= '0;
            msk_q   <= 4'd0;
            ers_q   <= 1'b0;
            idx_q   <= 2'd0;
            dx_q    <= 5'd0;
            dy_q    <= 5'd0;
            x       <= 8'd0;
            y       <= 7'd0;
            colour  <= 3'd0;
            plot    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            msk_q   <= msk_d;
            ers_q   <= ers_d;
            idx_q   <= idx_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            x       <= x_d;
            y       <= y_d;
            colour  <= colour_d;
            plot    <= plot_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_block_renderer.sv
// Directed bench for block_renderer: per-pixel reference walk plus hand-computed totals.
module tb_block_renderer;

    logic        clock;
    logic        reset;
    logic [15:0] block1, block2, block3, block4;
    logic [3:0]  mask;
    logic        start, erase;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot, busy, done;

    int asserts_cnt;
    int fails_cnt;

    block_renderer #(.LEN_PX(16), .THICK_PX(4)) dut (
        .clock  (clock),
        .reset  (reset),
        .block1 (block1),
        .block2 (block2),
        .block3 (block3),
        .block4 (block4),
        .mask   (mask),
        .start  (start),
        .erase  (erase),
        .x      (x),
        .y      (y),
        .colour (colour),
        .plot   (plot),
        .busy   (busy),
        .done   (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts_cnt++;
        if (obs !== exp) begin
            fails_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pulse start, then walk the expected pixel sequence from the given words.
    task automatic do_pass(input logic [15:0] b1, input logic [15:0] b2,
                           input logic [15:0] b3, input logic [15:0] b4,
                           input logic [3:0] m, input logic er, input bit tamper,
                           output int plots, output int last_x, output int last_y);
        logic [15:0] w [4];
        logic [2:0]  col [4];
        int n;
        w[0] = b1; w[1] = b2; w[2] = b3; w[3] = b4;
        col[0] = 3'b100; col[1] = 3'b010; col[2] = 3'b001; col[3] = 3'b110;
        plots = 0; last_x = -1; last_y = -1; n = 0;
        block1 = b1; block2 = b2; block3 = b3; block4 = b4;
        mask = m; erase = er; start = 1'b1;
        tick();
        start = 1'b0;
        for (int bi = 0; bi < 4; bi++) begin
            if (m[bi]) begin
                int bx, by, wd, ht;
                bx = int'(w[bi][8:1]);
                by = int'(w[bi][15:9]);
                wd = w[bi][0] ? 4 : 16;
                ht = w[bi][0] ? 16 : 4;
                for (int dy = 0; dy < ht; dy++) begin
                    for (int dx = 0; dx < wd; dx++) begin
                        logic [7:0] ex;
                        logic [6:0] ey;
                        ex = 8'(bx + dx);
                        ey = 7'(by + dy);
                        check("x", 32'(x), 32'(ex));
                        check("y", 32'(y), 32'(ey));
                        check("plot", 32'(plot), 32'((bx + dx < 160) && (by + dy < 120)));
                        check("colour", 32'(colour), 32'(er ? 3'b000 : col[bi]));
                        check("busy", 32'(busy), 32'd1);
                        check("done_in_draw", 32'(done), 32'd0);
                        if (plot) plots++;
                        last_x = int'(x);
                        last_y = int'(y);
                        n++;
                        if (tamper && n == 20) begin
                            block1 = 16'hFFFF; block2 = 16'hFFFF;
                            block3 = 16'hFFFF; block4 = 16'hFFFF;
                            mask = 4'b1111; erase = 1'b0; start = 1'b1;
                        end else begin
                            start = 1'b0;
                        end
                        tick();
                    end
                end
            end
        end
        start = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_fin", 32'(busy), 32'd0);
        check("plot_fin", 32'(plot), 32'd0);
        if (m != 4'b0000) begin
            check("x_hold", 32'(x), 32'(last_x));
            check("y_hold", 32'(y), 32'(last_y));
        end
        tick();
        check("done_drop", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int pc, lx, ly;
        asserts_cnt = 0;
        fails_cnt   = 0;
        reset = 1'b1; start = 1'b0; erase = 1'b0; mask = 4'b0000;
        block1 = 16'h0; block2 = 16'h0; block3 = 16'h0; block4 = 16'h0;
        tick();
        tick();
        check("rst_x", 32'(x), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_colour", 32'(colour), 32'd0);
        check("rst_plot", 32'(plot), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();

        // Abort mid-pass with async reset at pixel 10.
        block1 = 16'h2814; mask = 4'b0001; erase = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("pre_rst_x", 32'(x), 32'd20);
        #2 reset = 1'b1;
        #1;
        check("arst_x", 32'(x), 32'd0);
        check("arst_y", 32'(y), 32'd0);
        check("arst_colour", 32'(colour), 32'd0);
        check("arst_plot", 32'(plot), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_done", 32'(done), 32'd0);
            check("post_rst_busy", 32'(busy), 32'd0);
        end

        // block1 horizontal at (10,20), fully on screen.
        do_pass(16'h2814, 16'h0, 16'h0, 16'h0, 4'b0001, 1'b0, 1'b0, pc, lx, ly);
        check("b1_plots", 32'(pc), 32'd64);
        check("b1_last_x", 32'(lx), 32'd25);
        check("b1_last_y", 32'(ly), 32'd23);

        // block4 vertical at (150,100).
        do_pass(16'h0, 16'h0, 16'h0, 16'hC92D, 4'b1000, 1'b0, 1'b0, pc, lx, ly);
        check("b4_plots", 32'(pc), 32'd64);
        check("b4_last_x", 32'(lx), 32'd153);
        check("b4_last_y", 32'(ly), 32'd115);

        // block2 horizontal at (150,50) clipped at the right edge.
        do_pass(16'h0, 16'h652C, 16'h0, 16'h0, 4'b0010, 1'b0, 1'b0, pc, lx, ly);
        check("b2_plots", 32'(pc), 32'd40);
        check("b2_last_x", 32'(lx), 32'd165);
        check("b2_last_y", 32'(ly), 32'd53);

        // Erase pass over block1 and block3 with inputs disturbed mid-pass.
        do_pass(16'h2814, 16'h0, 16'h7850, 16'h0, 4'b0101, 1'b1, 1'b1, pc, lx, ly);
        check("er_plots", 32'(pc), 32'd128);
        check("er_last_x", 32'(lx), 32'd55);
        check("er_last_y", 32'(ly), 32'd63);

        // Empty mask: done immediately, nothing drawn.
        block1 = 16'h2814; mask = 4'b0000; erase = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check("empty_done", 32'(done), 32'd1);
        check("empty_busy", 32'(busy), 32'd0);
        check("empty_plot", 32'(plot), 32'd0);
        tick();
        check("empty_done_drop", 32'(done), 32'd0);
        check("empty_busy_idle", 32'(busy), 32'd0);
        check("empty_plot_idle", 32'(plot), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts_cnt, fails_cnt);
        $finish;
    end

endmodule
